// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan decoder: segment patterns,
// scan FSM encoding and the captured-frame record.
package seg7_pkg;

  // Active-low a..g patterns, seg[7:1] order (a is the MSB).
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_BLANK    = 2'd0,
    ST_SETTLING = 2'd1,
    ST_CAPTURED = 2'd2
  } scan_state_e;

  typedef struct packed {
    logic [31:0] value;
    logic [7:0]  dp;
    logic [7:0]  invalid;
  } frame_t;

  // Position of the lowest driven-low enable bit.
  function automatic logic [2:0] low_index(input logic [7:0] an_n);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!an_n[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment to hex-nibble decoder; unknown shapes,
// including an all-dark digit, are flagged invalid and read as zero.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_in,
  output logic [3:0] nibble,
  output logic       invalid
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    nibble  = 4'h0;
    invalid = 1'b0;
    case (seg_in)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
      SEG_BLANK: invalid = 1'b1;
      default:   invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers the eight hex digits shown on a multiplexed, active-low 7-segment
// display and publishes them once STABLE_FRAMES identical frames are seen.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned SETTLE        = 4,
  parameter int unsigned STABLE_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  seg,
  input  logic [7:0]  an,
  input  logic        clr,
  output logic [31:0] value,
  output logic [7:0]  dp_out,
  output logic [7:0]  invalid,
  output logic        frame_valid,
  output logic        locked,
  output logic        err_multi
);

  localparam logic [7:0] SETTLE_W = 8'(SETTLE);
  localparam logic [3:0] STABLE_W = 4'(STABLE_FRAMES);

  scan_state_e state_q, state_d;
  logic [7:0]  prev_an_q, prev_an_d;
  logic [7:0]  prev_seg_q, prev_seg_d;
  logic [7:0]  run_q, run_d;
  logic [7:0]  mask_q, mask_d;
  logic [3:0]  match_q, match_d;
  frame_t      shadow_q, shadow_d;
  frame_t      last_q, last_d;
  frame_t      out_q, out_d;
  logic        frame_valid_q, frame_valid_d;
  logic        locked_q, locked_d;
  logic        err_multi_q, err_multi_d;

  logic [7:0]  an_low;
  logic        one_low;
  logic        multi_low;
  logic        changed;
  logic        sample;
  logic [2:0]  sel;
  logic [3:0]  dec_nibble;
  logic        dec_invalid;

  seg7_decode u_decode (
    .seg_in  (seg[7:1]),
    .nibble  (dec_nibble),
    .invalid (dec_invalid)
  );

  assign an_low    = ~an;
  assign one_low   = (an_low != 8'h00) && ((an_low & (an_low - 8'd1)) == 8'h00);
  assign multi_low = (an_low != 8'h00) && !one_low;
  assign changed   = (an != prev_an_q) || (seg != prev_seg_q);
  assign sel       = low_index(an);

  // NOTE: combinational next-state logic uses blocking '=', flops use '<='.
  always_comb begin
    state_d       = state_q;
    prev_an_d     = an;
    prev_seg_d    = seg;
    mask_d        = mask_q;
    match_d       = match_q;
    shadow_d      = shadow_q;
    last_d        = last_q;
    out_d         = out_q;
    frame_valid_d = 1'b0;
    locked_d      = locked_q;
    err_multi_d   = err_multi_q;
    sample        = 1'b0;

    // Cycles the present an/seg pair has been held, this cycle included.
    if (changed)             run_d = 8'd1;
    else if (run_q == 8'hFF) run_d = run_q;
    else                     run_d = run_q + 8'd1;

    if (multi_low) err_multi_d = 1'b1;

    // A window is one unbroken run of the same single-digit an/seg pair.
    if (!one_low) begin
      state_d = ST_BLANK;
    end else if (state_q == ST_CAPTURED && !changed) begin
      state_d = ST_CAPTURED;
    end else if (run_d >= SETTLE_W) begin
      sample  = 1'b1;
      state_d = ST_CAPTURED;
    end else begin
      state_d = ST_SETTLING;
    end

    if (sample) begin
      shadow_d.value[{sel, 2'b00} +: 4] = dec_nibble;
      shadow_d.dp[sel]                  = ~seg[0];
      shadow_d.invalid[sel]             = dec_invalid;
      mask_d[sel]                       = 1'b1;
    end

    if (mask_d == 8'hFF) begin
      if (shadow_d == last_q)
        match_d = (match_q >= STABLE_W) ? STABLE_W : match_q + 4'd1;
      else
        match_d = 4'd1;
      last_d = shadow_d;
      mask_d = 8'h00;
      if (match_d == STABLE_W) begin
        out_d         = shadow_d;
        frame_valid_d = 1'b1;
        locked_d      = 1'b1;
      end
    end

    // Clear overrides whatever sample or publication happened this cycle.
    if (clr) begin
      state_d       = ST_BLANK;
      prev_an_d     = 8'hFF;
      prev_seg_d    = 8'hFF;
      run_d         = 8'd0;
      mask_d        = 8'h00;
      match_d       = 4'd0;
      shadow_d      = '0;
      last_d        = '0;
      out_d         = '0;
      frame_valid_d = 1'b0;
      locked_d      = 1'b0;
      err_multi_d   = 1'b0;
    end
  end

  // NOTE: the shadow and previous-frame registers are reset too; a frame
  // comparison right after reset must see a defined all-zero frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BLANK;
      prev_an_q     <= 8'hFF;
      prev_seg_q    <= 8'hFF;
      run_q         <= 8'd0;
      mask_q        <= 8'h00;
      match_q       <= 4'd0;
      shadow_q      <= '0;
      last_q        <= '0;
      out_q         <= '0;
      frame_valid_q <= 1'b0;
      locked_q      <= 1'b0;
      err_multi_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_an_q     <= prev_an_d;
      prev_seg_q    <= prev_seg_d;
      run_q         <= run_d;
      mask_q        <= mask_d;
      match_q       <= match_d;
      shadow_q      <= shadow_d;
      last_q        <= last_d;
      out_q         <= out_d;
      frame_valid_q <= frame_valid_d;
      locked_q      <= locked_d;
      err_multi_q   <= err_multi_d;
    end
  end

  assign value       = out_q.value;
  assign dp_out      = out_q.dp;
  assign invalid     = out_q.invalid;
  assign frame_valid = frame_valid_q;
  assign locked      = locked_q;
  assign err_multi   = err_multi_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench: a window/frame level model predicts every output each
// cycle, and directed scenarios pin the model with literal expectations.
module tb_seg7_scan_decoder;

  localparam int SETTLE        = 4;
  localparam int STABLE_FRAMES = 2;

  localparam logic [6:0] PAT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  seg = 8'hFF;
  logic [7:0]  an = 8'hFF;
  logic        clr = 1'b0;
  logic [31:0] value;
  logic [7:0]  dp_out;
  logic [7:0]  invalid;
  logic        frame_valid;
  logic        locked;
  logic        err_multi;

  int total = 0;
  int bad = 0;
  int fv_count = 0;
  bit run_cmp = 1'b0;

  seg7_scan_decoder #(.SETTLE(SETTLE), .STABLE_FRAMES(STABLE_FRAMES)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg         (seg),
    .an          (an),
    .clr         (clr),
    .value       (value),
    .dp_out      (dp_out),
    .invalid     (invalid),
    .frame_valid (frame_valid),
    .locked      (locked),
    .err_multi   (err_multi)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] enc(input logic [3:0] d, input bit dp_lit);
    return {PAT[d], ~dp_lit};
  endfunction

  // ---------------- behavioural model ----------------
  logic [7:0]  m_prev_an, m_prev_seg;
  int          m_run;
  bit          m_done;
  logic [3:0]  m_nib  [8];
  bit          m_dp   [8];
  bit          m_inv  [8];
  bit          m_have [8];
  logic [3:0]  l_nib  [8];
  bit          l_dp   [8];
  bit          l_inv  [8];
  int          m_streak;
  logic [31:0] e_value = '0;
  logic [7:0]  e_dp = '0;
  logic [7:0]  e_inv = '0;
  bit          e_fv = 1'b0;
  bit          e_locked = 1'b0;
  bit          e_err = 1'b0;

  task automatic reset_model();
    m_prev_an = 8'hFF; m_prev_seg = 8'hFF; m_run = 0; m_done = 1'b0; m_streak = 0;
    for (int i = 0; i < 8; i++) begin
      m_nib[i] = '0; m_dp[i] = 0; m_inv[i] = 0; m_have[i] = 0;
      l_nib[i] = '0; l_dp[i] = 0; l_inv[i] = 0;
    end
    e_value = '0; e_dp = '0; e_inv = '0; e_fv = 0; e_locked = 0; e_err = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    int  zeros, idx, k;
    bit  same, full, equal;
    if (!rst_n || clr) begin
      reset_model();
    end else begin
      zeros = 0; idx = 0;
      for (int i = 0; i < 8; i++) if (!an[i]) begin zeros++; idx = i; end
      same  = (an == m_prev_an) && (seg == m_prev_seg);
      m_run = same ? ((m_run < 255) ? m_run + 1 : 255) : 1;
      e_fv  = 1'b0;
      if (zeros > 1) e_err = 1'b1;
      if (zeros != 1 || !same) m_done = 1'b0;
      if (zeros == 1 && !m_done && m_run >= SETTLE) begin
        m_done = 1'b1;
        m_nib[idx] = 4'h0; m_inv[idx] = 1'b1;
        for (k = 0; k < 16; k++) if (PAT[k] == seg[7:1]) begin
          m_nib[idx] = 4'(k); m_inv[idx] = 1'b0;
        end
        m_dp[idx]   = !seg[0];
        m_have[idx] = 1'b1;
        full = 1'b1;
        for (int i = 0; i < 8; i++) full &= m_have[i];
        if (full) begin
          equal = 1'b1;
          for (int i = 0; i < 8; i++)
            if (m_nib[i] != l_nib[i] || m_dp[i] != l_dp[i] || m_inv[i] != l_inv[i]) equal = 1'b0;
          m_streak = equal ? ((m_streak < STABLE_FRAMES) ? m_streak + 1 : STABLE_FRAMES) : 1;
          for (int i = 0; i < 8; i++) begin
            l_nib[i] = m_nib[i]; l_dp[i] = m_dp[i]; l_inv[i] = m_inv[i]; m_have[i] = 0;
          end
          if (m_streak == STABLE_FRAMES) begin
            for (int i = 0; i < 8; i++) begin
              e_value[4*i +: 4] = m_nib[i]; e_dp[i] = m_dp[i]; e_inv[i] = m_inv[i];
            end
            e_fv = 1'b1; e_locked = 1'b1;
          end
        end
      end
      m_prev_an = an; m_prev_seg = seg;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (run_cmp) begin
      check("value", value, e_value);
      check("dp_out", {24'h0, dp_out}, {24'h0, e_dp});
      check("invalid", {24'h0, invalid}, {24'h0, e_inv});
      check("frame_valid", {31'h0, frame_valid}, {31'h0, e_fv});
      check("locked", {31'h0, locked}, {31'h0, e_locked});
      check("err_multi", {31'h0, err_multi}, {31'h0, e_err});
      if (frame_valid) fv_count++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic show(input int d, input logic [7:0] s, input int n);
    an  = ~(8'(8'h01 << d));
    seg = s;
    cycles(n);
  endtask

  task automatic blank(input int n);
    an = 8'hFF; seg = 8'hFF;
    cycles(n);
  endtask

  task automatic frame_word(input logic [31:0] w);
    for (int i = 0; i < 8; i++) show(i, enc(w[4*i +: 4], 1'b0), 6);
    blank(2);
  endtask

  task automatic frame_segs(input logic [63:0] s);
    for (int i = 0; i < 8; i++) show(i, s[8*i +: 8], 6);
    blank(2);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    cycles(1);
    clr = 1'b0;
  endtask

  initial begin
    int fv0;
    logic [63:0] segs;
    reset_model();
    cycles(3);
    run_cmp = 1'b1;
    check("rst_value", value, 32'h0);
    check("rst_locked", {31'h0, locked}, 32'h0);
    rst_n = 1'b1;
    blank(3);

    // Two identical frames publish exactly once.
    fv0 = fv_count;
    frame_word(32'h87654321);
    check("one_frame_no_pub", fv_count, fv0);
    frame_word(32'h87654321);
    check("pair_pulses", fv_count, fv0 + 1);
    check("pair_value", value, 32'h87654321);
    check("pair_locked", {31'h0, locked}, 32'h1);
    check("model_value", e_value, 32'h87654321);

    // A, B, B: publication only after the second B.
    fv0 = fv_count;
    frame_word(32'h0123ABCD);
    frame_word(32'hFEDC9876);
    check("ab_no_pub", fv_count, fv0);
    check("ab_hold", value, 32'h87654321);
    frame_word(32'hFEDC9876);
    check("bb_pub", fv_count, fv0 + 1);
    check("bb_value", value, 32'hFEDC9876);

    // Re-sampling a digit before the frame completes overwrites its slot.
    show(0, enc(4'h9, 1'b0), 6);
    frame_word(32'hFEDC9873);
    frame_word(32'hFEDC9873);
    check("overwrite_value", value, 32'hFEDC9873);

    // Dark digit 3 is invalid; digit 0 shows 0 with its dp lit.
    segs = {8{enc(4'h1, 1'b0)}};
    segs[7:0]   = 8'b00000010;
    segs[31:24] = 8'hFF;
    frame_segs(segs);
    frame_segs(segs);
    check("inv_mask", {24'h0, invalid}, 32'h08);
    check("dp_mask", {24'h0, dp_out}, 32'h01);
    check("inv_nibble", {28'h0, value[15:12]}, 32'h0);
    check("dp_nibble", {28'h0, value[3:0]}, 32'h0);
    check("inv_value", value, 32'h11110110);

    // Multi-low enables: sticky error, partial frame survives.
    fv0 = fv_count;
    for (int i = 0; i < 4; i++) show(i, enc(4'h2, 1'b0), 6);
    an = 8'b11111100; seg = enc(4'h2, 1'b0);
    cycles(10);
    check("multi_err", {31'h0, err_multi}, 32'h1);
    for (int i = 4; i < 8; i++) show(i, enc(4'h2, 1'b0), 6);
    blank(2);
    frame_word(32'h22222222);
    check("multi_mask_kept", fv_count, fv0 + 1);
    check("multi_value", value, 32'h22222222);
    pulse_clr();
    check("clr_err", {31'h0, err_multi}, 32'h0);
    check("clr_locked", {31'h0, locked}, 32'h0);
    check("clr_value", value, 32'h0);

    // Segments changing faster than SETTLE never produce a sample.
    fv0 = fv_count;
    for (int k = 0; k < 10; k++) begin
      show(0, enc(4'h1, 1'b0), 3);
      show(0, enc(4'h2, 1'b0), 3);
    end
    for (int r = 0; r < 2; r++)
      for (int i = 1; i < 8; i++) show(i, enc(4'h5, 1'b0), 6);
    blank(2);
    check("toggle_no_pub", fv_count, fv0);
    check("toggle_value", value, 32'h0);
    pulse_clr();

    // Reset mid-frame discards the partial frame and the match history.
    frame_word(32'hC0FFEE42);
    frame_word(32'hC0FFEE42);
    check("pre_rst_value", value, 32'hC0FFEE42);
    for (int i = 0; i < 5; i++) show(i, enc(4'h3, 1'b0), 6);
    rst_n = 1'b0;
    cycles(2);
    check("midrst_value", value, 32'h0);
    check("midrst_locked", {31'h0, locked}, 32'h0);
    check("midrst_inv", {24'h0, invalid}, 32'h0);
    rst_n = 1'b1;
    blank(2);
    fv0 = fv_count;
    frame_word(32'hC0FFEE42);
    check("post_rst_single", fv_count, fv0);
    frame_word(32'hC0FFEE42);
    check("post_rst_pair", fv_count, fv0 + 1);
    check("post_rst_value", value, 32'hC0FFEE42);

    run_cmp = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 SHALL have parameter SETTLE, default 4: cycles an/seg must hold unchanged before a digit is sampled (range 1..255).
REQ-002 SHALL have parameter STABLE_FRAMES, default 2: consecutive identical complete frames required before the outputs update (range 1..15).
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port seg  input  8: active-low segments, bit7=a, 6=b, 5=c, 4=d, 3=e, 2=f, 1=g, 0=dp.
REQ-006 SHALL have port an  input  8: active-low digit enables; bit i low selects digit i.
REQ-007 SHALL have port clr  input  1: synchronous clear of all state to reset values.
REQ-008 SHALL have port value  output  32: decoded hex digits; digit i occupies value[4i+3:4i].
REQ-009 SHALL have port dp_out  output  8: bit i = 1 when digit i's dp was lit (seg[0]=0).
REQ-010 SHALL have port invalid  output  8: bit i = 1 when digit i's seg[7:1] matched no table entry.
REQ-011 SHALL have port frame_valid  output  1: one-cycle pulse when value/dp_out/invalid update.
REQ-012 SHALL have port locked  output  1: high once any frame has been published.
REQ-013 SHALL have port err_multi  output  1: sticky; set when more than one an bit is low.

Function
REQ-014 SHALL decode seg[7:1] as: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000; any other pattern gives nibble 0 and invalid=1.
REQ-015 SHALL run a per-window FSM: BLANK (an=8'hFF or multi-low), SETTLING (exactly one an bit low, counter running), CAPTURED (sample taken; wait for an/seg change).
REQ-016 SHALL, in SETTLING, reset the settle counter whenever an or seg differs from the previous cycle.
REQ-017 SHALL sample when the counter reaches SETTLE: write nibble, dp and invalid into shadow slot i, set captured-mask bit i, enter CAPTURED; exactly one sample per enable window.
REQ-018 SHALL leave CAPTURED for SETTLING (new window) on any an or seg change, or for BLANK when an becomes all-ones or multi-low.
REQ-019 SHALL, on multi-low an, set err_multi, take no sample, and leave the captured mask unchanged.
REQ-020 SHALL overwrite shadow slot i if digit i is sampled again before the frame completes; the mask is unchanged.
REQ-021 SHALL complete a frame the cycle the mask becomes 8'hFF; that same cycle it compares the shadow with the previous frame, sets match count to min(count+1, STABLE_FRAMES) when equal or to 1 when different, saves the shadow as the previous frame, and clears the mask.
REQ-022 SHALL, when the match count reaches STABLE_FRAMES at frame completion, update value/dp_out/invalid on the next edge with frame_valid high for exactly that cycle and locked set; later identical frames re-pulse frame_valid.
REQ-023 SHALL give clr priority over a simultaneous sample or frame completion.
REQ-024 SHALL hold value/dp_out/invalid unchanged between publications.

Reset
REQ-025 SHALL, while rst_n=0 or on clr, force value=0, dp_out=0, invalid=0, frame_valid=0, locked=0, err_multi=0, mask=0, match count=0, previous frame=0, FSM=BLANK.
REQ-026 SHALL discard any partial frame when reset asserts mid-frame; capture restarts from an empty mask after release.

Structure
REQ-027 SHALL place the 16 segment-pattern constants, SEG_BLANK=7'b1111111 and the FSM state encoding in a shared package seg7_pkg.
REQ-028 SHALL implement the REQ-014 table as a combinational sub-module seg7_decode (in seg[7:1]; out nibble, invalid).

Verification
REQ-029 SHALL test: scan digits 0..7 showing 1,2,3,4,5,6,7,8 with SETTLE=4, STABLE_FRAMES=2, two frames -> one frame_valid pulse, value=32'h87654321, locked=1.
REQ-030 SHALL test: digit 3 seg=8'b11111111 -> invalid=8'h08, value[15:12]=0; digit 0 seg=8'b00000010 -> dp_out[0]=1, value[3:0]=0.
REQ-031 SHALL test: an=8'b11111100 for 10 cycles -> err_multi=1, mask unchanged; clr -> err_multi=0.
REQ-032 SHALL test: seg toggling every 3 cycles with SETTLE=4 -> no sample, no frame_valid.
REQ-033 SHALL test: frame A, frame B, then frame B -> frame_valid fires only after the second B with value=B.
REQ-034 SHALL test: rst_n low after 5 of 8 digits are captured -> all outputs 0; a full frame pair after release is still needed to publish.
